sequence_generator: RTL
=======================

Name: sequence_generator

Overview:
- Serial stimulus transmitter. On request, it emits one 01[0*]1 frame on a single-bit line: 0, 1, N zeros, 1.
- N is taken from the request.
- Counts completed frames and shows the count (mod 100) on two 7-segment digits.
- Sits upstream of the sequence-detection path; used as on-board pattern source and self-test driver.

Parameters:
- GAP_W, 4, width of zero-gap length field; max gap = 2^GAP_W-1.
- CNT_W, 7, width of internal frame counter bookkeeping (must hold 0..99).

Ports:
- clk  input  1  main clock
- rst  input  1  reset; synchronous, active-high
- ena  input  1  enable; low = freeze all state
- req_valid  input  1  frame request
- req_gap  input  GAP_W  number of zeros between the two 1s
- req_ready  output  1  request accepted on clk edge when req_valid & req_ready
- sig_out  output  1  serial output; idle level 1
- frame  output  1  high while a frame bit is on sig_out
- done  output  1  one-cycle pulse coincident with final 1 of a frame
- disp0  output  7  ones digit, active-low segments {g..a}
- disp1  output  7  tens digit, active-low segments

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; sig_out=1; frame=0; done=0.
  - Count=0; disp0=disp1=7'b1000000 ("0").
  - Applies mid-frame too: the frame is abandoned, no done, count unchanged from 0.
- States (registered), with sig_out per state:
  - IDLE: 1, frame=0.
  - LEAD0: 0.
  - LEAD1: 1.
  - GAP: 0.
  - TAIL1: 1, frame=1.
  - frame=1 in LEAD0, LEAD1, GAP and TAIL1.
- Handshake:
  - req_ready = ena & (state==IDLE | state==TAIL1).
  - Accept edge: latch req_gap into gap_cnt; next state LEAD0.
  - First 0 appears in the cycle after acceptance.
- Transitions (only when ena=1):
  - LEAD0 -> LEAD1.
  - LEAD1 -> GAP if gap_cnt!=0, else TAIL1.
  - GAP: decrement gap_cnt; go to TAIL1 when gap_cnt==1, else stay.
  - TAIL1 -> LEAD0 if a request is accepted (back-to-back, no idle 1), else IDLE.
- Frame length = req_gap+3 cycles (ena continuously high).
- ena=0: state, gap_cnt, sig_out, count and displays all hold. req_ready=0. done not regenerated.
- done:
  - Registered; set on the edge entering TAIL1, cleared on the next edge.
  - Exactly one pulse per frame, even if ena drops during TAIL1.
- Count:
  - Two BCD digits; increments on the edge entering TAIL1.
  - 99 wraps to 00.
  - Displays are registered decodes of the digits, updated when ena=1. The new value is visible from the cycle after done.
- req_gap changes after acceptance have no effect on the frame in flight.
- Unused/illegal state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro: SEQGEN_DISPLAY_EN.
- Defined: BCD counter, decoders and disp0/disp1 behave as above.
- Undefined: counter and decoders are removed; disp0 and disp1 are constant 7'b1111111 (blank).
- sig_out, frame, done and req_ready timing are identical in both builds.

Decomposition:
- Package seqgen_pkg:
  - state enum (IDLE, LEAD0, LEAD1, GAP, TAIL1).
  - Segment constants SEG_0..SEG_9, SEG_BLANK=7'b1111111, SEG_ERR=7'b0000111.
  - IDLE_LEVEL=1'b1.
- Sub-module seg7_digit: 4-bit BCD in, 7-bit active-low segments out, combinational. Values >9 decode to SEG_ERR. Instantiated twice.

Test Plan:
- Reset, then gap=0 request at cycle 0 -> sig_out cycles 1..3 = 0,1,1 then idle 1; frame high 3 cycles; done high cycle 3; disp0=7'b1111001 from cycle 4.
- gap=3 -> sig_out 0,1,0,0,0,1, frame high 6 cycles, single done on the 6th, count=1.
- Two back-to-back requests gap=1 (valid held) -> sig_out 0,1,0,1,0,1,0,1 with no idle 1; two done pulses 4 cycles apart; disp0=7'b0100100.
- ena low for 4 cycles during GAP of a gap=2 frame -> sig_out held 0; req_ready=0; frame length 9 cycles; one done.
- 100 frames gap=0 -> disp shows 99 after the 99th, then disp0=disp1=7'b1000000 after the 100th.
- rst high for one cycle mid-GAP -> next cycle sig_out=1, frame=0, req_ready=1, displays "00", no done pulse.

Source files
------------

// File: rtl/seqgen_pkg.sv
// Shared types and constants for the serial frame generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seqgen_pkg;

   // Frame state; the encodings 3'd5..3'd7 are unused and recover to IDLE.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEAD0 = 3'd1,
      LEAD1 = 3'd2,
      GAP   = 3'd3,
      TAIL1 = 3'd4
   } state_t;

   // Line level while no frame is being sent.
   localparam logic IDLE_LEVEL = 1'b1;

   // Active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ERR   = 7'b0000111;

endpackage

// File: rtl/sequence_generator_seg7_digit.sv
// seg7_digit: BCD digit to active-low 7-segment pattern decoder.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   bcd  in  4  BCD digit; codes above 9 show SEG_ERR
//   seg  out 7  active-low segments {g..a}
//
// Only built with SEQGEN_DISPLAY_EN defined; the blank-display build has no
// decoders, so the module is left out rather than floating as a second top.
`ifdef SEQGEN_DISPLAY_EN
module seg7_digit
   import seqgen_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_ERR;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_ERR;
      endcase
   end

endmodule
`endif

// File: rtl/sequence_generator.sv
// sequence_generator: emits one 0,1,<N zeros>,1 frame per accepted request.
// Latency: first frame bit one cycle after the accept edge; frame is N+3 cycles.
// Backpressure: req_ready only in IDLE/TAIL1 with ena high; ena low freezes all.
//
// Ports:
//   clk        in   1      clock
//   rst        in   1      synchronous active-high reset
//   ena        in   1      clock enable; low holds every register
//   req_valid  in   1      frame request
//   req_gap    in   GAP_W  zeros between the two 1s of the frame
//   req_ready  out  1      request taken on an edge with req_valid & req_ready
//   sig_out    out  1      serial line, idles at 1
//   frame      out  1      high while a frame bit is on sig_out
//   done       out  1      one-cycle pulse with the final 1 of each frame
//   disp0      out  7      frame count ones digit, active-low segments
//   disp1      out  7      frame count tens digit, active-low segments
//
// Build option SEQGEN_DISPLAY_EN: when defined, frames are counted mod 100 and
// shown on disp0/disp1; when undefined, both displays are held blank.
module sequence_generator
   import seqgen_pkg::*;
#(
   parameter int GAP_W = 4,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             req_valid,
   input  logic [GAP_W-1:0] req_gap,
   output logic             req_ready,
   output logic             sig_out,
   output logic             frame,
   output logic             done,
   output logic [6:0]       disp0,
   output logic [6:0]       disp1
);

   // The frame counter has to reach 99.
   if (CNT_W < 7) begin : g_cnt_w_check
      $error("sequence_generator: CNT_W must be at least 7");
   end

   state_t           state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             done_q;
   logic             accept;
   logic             enter_tail;

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      req_ready = ena && (state_q == IDLE || state_q == TAIL1);
      accept    = req_valid && req_ready;
      sig_out   = IDLE_LEVEL;
      frame     = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = LEAD0;
               gap_d   = req_gap;
            end
         end
         LEAD0: begin
            sig_out = 1'b0;
            frame   = 1'b1;
            if (ena) state_d = LEAD1;
         end
         LEAD1: begin
            sig_out = 1'b1;
            frame   = 1'b1;
            if (ena) state_d = (gap_q != '0) ? GAP : TAIL1;
         end
         GAP: begin
            // gap_q counts the zeros still to send, including this one.
            sig_out = 1'b0;
            frame   = 1'b1;
            if (ena) begin
               gap_d = gap_q - GAP_W'(1);
               if (gap_q == GAP_W'(1)) state_d = TAIL1;
            end
         end
         TAIL1: begin
            // A request taken here chains straight into the next frame
            // with no idle 1 in between.
            sig_out = 1'b1;
            frame   = 1'b1;
            if (ena) begin
               if (accept) begin
                  state_d = LEAD0;
                  gap_d   = req_gap;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            // Unused encodings fall back to IDLE even with ena low.
            state_d = IDLE;
         end
      endcase

      // TAIL1 can never follow itself, so this marks exactly one edge per
      // frame; it can only fire with ena high since state holds otherwise.
      enter_tail = (state_d == TAIL1) && (state_q != TAIL1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gap_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         // Cleared on the following edge regardless of ena, so a pulse
         // never stretches when ena drops during TAIL1.
         done_q  <= enter_tail;
      end
   end

   assign done = done_q;

`ifdef SEQGEN_DISPLAY_EN
   logic [CNT_W-1:0] frames_q;
   logic [3:0]       ones_q, tens_q;
   logic [6:0]       seg_ones, seg_tens;
   logic [6:0]       disp0_q, disp1_q;

   seg7_digit u_ones (
      .bcd (ones_q),
      .seg (seg_ones)
   );

   seg7_digit u_tens (
      .bcd (tens_q),
      .seg (seg_tens)
   );

   // frames_q tracks the binary count so the 99 -> 00 wrap is a single
   // compare instead of a two-digit decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         frames_q <= '0;
         ones_q   <= 4'd0;
         tens_q   <= 4'd0;
         disp0_q  <= SEG_0;
         disp1_q  <= SEG_0;
      end else if (ena) begin
         // Displays sample the digits before this edge's increment, so a
         // new count shows up the cycle after done.
         disp0_q <= seg_ones;
         disp1_q <= seg_tens;
         if (enter_tail) begin
            if (frames_q == CNT_W'(99)) begin
               frames_q <= '0;
               ones_q   <= 4'd0;
               tens_q   <= 4'd0;
            end else begin
               frames_q <= frames_q + CNT_W'(1);
               if (ones_q == 4'd9) begin
                  ones_q <= 4'd0;
                  tens_q <= tens_q + 4'd1;
               end else begin
                  ones_q <= ones_q + 4'd1;
               end
            end
         end
      end
   end

   assign disp0 = disp0_q;
   assign disp1 = disp1_q;
`else
   assign disp0 = SEG_BLANK;
   assign disp1 = SEG_BLANK;
`endif

endmodule
